// File: rtl/led_heartbeat_array.sv
// N-channel LED driver / heartbeat: per-channel divider, mode (off/on/blink/pwm) and wrap tick strobe.
// Define LED_HEARTBEAT_PWM_EN to implement PWM mode 3; otherwise mode 3 behaves as BLINK.
module led_heartbeat_array #(
  parameter int NUM_CH       = 10,
  parameter int DIV_WIDTH    = 26,
  parameter int DIV_DEFAULT  = 3,
  parameter int MODE_DEFAULT = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [$clog2(NUM_CH+1)-1:0] cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [7:0]                  cfg_duty,
  input  logic                        sync_all,
  output logic [NUM_CH-1:0]           led,
  output logic [NUM_CH-1:0]           tick
);

  localparam int         CH_W       = $clog2(NUM_CH+1);
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

`ifndef LED_HEARTBEAT_PWM_EN
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]           mode_q, mode_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 blink_q, blink_d;
    logic                 tick_q, tick_d;
    logic                 wr, restart, wrap, led_ch;
`ifdef LED_HEARTBEAT_PWM_EN
    logic [7:0]           duty_q, duty_d;
    logic [7:0]           ph_q, ph_d;
`endif

    // Out-of-range cfg_ch never matches any channel index, so such writes are dropped.
    assign wr      = cfg_we && (cfg_ch == CH_W'(i));
    assign restart = wr || sync_all;
    assign wrap    = (cnt_q >= div_q);

    always_comb begin
      mode_d  = mode_q;
      div_d   = div_q;
      cnt_d   = cnt_q + DIV_WIDTH'(1);
      blink_d = blink_q;
      tick_d  = 1'b0;
`ifdef LED_HEARTBEAT_PWM_EN
      duty_d  = duty_q;
      ph_d    = ph_q;
`endif
      if (wrap) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
        tick_d  = 1'b1;
`ifdef LED_HEARTBEAT_PWM_EN
        ph_d    = ph_q + 8'd1;
`endif
      end
      // A restart (write or sync) overrides a same-cycle wrap, suppressing its tick.
      if (restart) begin
        cnt_d   = '0;
        blink_d = 1'b0;
        tick_d  = 1'b0;
`ifdef LED_HEARTBEAT_PWM_EN
        ph_d    = 8'd0;
`endif
      end
      if (wr) begin
        mode_d = cfg_mode;
        div_d  = cfg_div;
`ifdef LED_HEARTBEAT_PWM_EN
        duty_d = cfg_duty;
`endif
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        mode_q  <= 2'(MODE_DEFAULT);
        div_q   <= DIV_WIDTH'(DIV_DEFAULT);
        cnt_q   <= '0;
        blink_q <= 1'b0;
        tick_q  <= 1'b0;
`ifdef LED_HEARTBEAT_PWM_EN
        duty_q  <= 8'd128;
        ph_q    <= 8'd0;
`endif
      end else begin
        mode_q  <= mode_d;
        div_q   <= div_d;
        cnt_q   <= cnt_d;
        blink_q <= blink_d;
        tick_q  <= tick_d;
`ifdef LED_HEARTBEAT_PWM_EN
        duty_q  <= duty_d;
        ph_q    <= ph_d;
`endif
      end
    end

    always_comb begin
      led_ch = 1'b0;
      case (mode_q)
        MODE_OFF:   led_ch = 1'b0;
        MODE_ON:    led_ch = 1'b1;
        MODE_BLINK: led_ch = blink_q;
`ifdef LED_HEARTBEAT_PWM_EN
        default:    led_ch = (ph_q < duty_q);
`else
        default:    led_ch = blink_q;
`endif
      endcase
    end

    assign led[i]  = led_ch;
    assign tick[i] = tick_q;
  end

endmodule

// File: tb/tb_led_heartbeat_array.sv
// Scoreboard bench: driver pushes expected led/tick per edge from an arithmetic model; monitor pops and compares.
`timescale 1ns/1ps
module tb_led_heartbeat_array;
  localparam int NUM_CH       = 10;
  localparam int DIV_WIDTH    = 26;
  localparam int DIV_DEFAULT  = 3;
  localparam int MODE_DEFAULT = 2;
  localparam int CH_W         = $clog2(NUM_CH+1);

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic [1:0]           cfg_mode;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [7:0]           cfg_duty;
  logic                 sync_all;
  logic [NUM_CH-1:0]    led;
  logic [NUM_CH-1:0]    tick;

  always #5 clock = ~clock;

  led_heartbeat_array #(
    .NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH),
    .DIV_DEFAULT(DIV_DEFAULT), .MODE_DEFAULT(MODE_DEFAULT)
  ) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_duty(cfg_duty),
    .sync_all(sync_all), .led(led), .tick(tick)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit started = 1'b0;
  bit done    = 1'b0;
  logic [2*NUM_CH-1:0] exp_q[$];
  logic [NUM_CH-1:0]   last_led;

  // Model: each channel counts edges since its last restart; wraps = edges / (div+1).
  longint unsigned m_n[NUM_CH];
  longint unsigned m_div[NUM_CH];
  int              m_duty[NUM_CH];
  int              m_mode[NUM_CH];

  function automatic logic [2*NUM_CH-1:0] predict();
    logic [NUM_CH-1:0] l;
    logic [NUM_CH-1:0] t;
    longint unsigned per, w;
    int md;
    l = '0;
    t = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      per  = m_div[i] + 1;
      w    = m_n[i] / per;
      t[i] = (m_n[i] != 0) && (m_n[i] % per == 0);
      md   = m_mode[i];
`ifndef LED_HEARTBEAT_PWM_EN
      if (md == 3) md = 2;
`endif
      case (md)
        0:       l[i] = 1'b0;
        1:       l[i] = 1'b1;
        2:       l[i] = w[0];
        default: l[i] = ((w % 256) < longint'(m_duty[i]));
      endcase
    end
    return {l, t};
  endfunction

  task automatic step(input bit rst, input bit we, input int ch, input int mode,
                      input longint unsigned div, input int duty, input bit sync);
    @(negedge clock);
    last_led = led;
    reset    = rst;
    cfg_we   = we;
    cfg_ch   = CH_W'(ch);
    cfg_mode = 2'(mode);
    cfg_div  = DIV_WIDTH'(div);
    cfg_duty = 8'(duty);
    sync_all = sync;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_mode[i] = MODE_DEFAULT; m_div[i] = DIV_DEFAULT; m_duty[i] = 128; m_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) m_n[i] = sync ? 0 : m_n[i] + 1;
      if (we && ch < NUM_CH) begin
        m_mode[ch] = mode; m_div[ch] = div; m_duty[ch] = duty; m_n[ch] = 0;
      end
    end
    exp_q.push_back(predict());
    started = 1'b1;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int mode, input longint unsigned div, input int duty);
    step(0, 1, ch, mode, div, duty, 0);
  endtask

  // Monitor
  initial begin : monitor
    logic [2*NUM_CH-1:0] e;
    forever begin
      @(posedge clock);
      #1;
      if (done) break;
      if (started) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty cyc=%0d got no expectation, required one per edge", cyc);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (led !== e[2*NUM_CH-1:NUM_CH]) begin
            bad++;
            $display("FAIL led cyc=%0d got=%b exp=%b", cyc, led, e[2*NUM_CH-1:NUM_CH]);
          end
          total++;
          if (tick !== e[NUM_CH-1:0]) begin
            bad++;
            $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, e[NUM_CH-1:0]);
          end
        end
      end
    end
  end

  initial begin : driver
    int on_cnt, exp_on, r, ch, mode, duty, pick;
    bit rst, sync, we;
    longint unsigned div;
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_div = '0; cfg_duty = '0; sync_all = 1'b0;

    // Reset then free-running default blink
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(12);
    // ch2 forced on; others undisturbed
    wr(2, 1, 3, 128);
    idle(8);
    // Out-of-range channel writes are ignored
    wr(NUM_CH, 0, 0, 0);
    idle(3);
    wr(15, 0, 1, 0);
    idle(6);
    // ch5 PWM, div 0, duty 64
    wr(5, 3, 0, 64);
    on_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      on_cnt += int'(last_led[5]);
    end
`ifdef LED_HEARTBEAT_PWM_EN
    exp_on = 64;
`else
    exp_on = 128;
`endif
    total++;
    if (on_cnt != exp_on) begin
      bad++;
      $display("FAIL pwm_count got=%0d exp=%0d", on_cnt, exp_on);
    end
    // Stagger phases, then sync_all; then sync with a simultaneous write
    wr(7, 2, 5, 0);
    idle(2);
    wr(8, 2, 2, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(10);
    step(0, 1, 4, 2, 1, 0, 1);
    idle(8);
    // Reset mid-operation with ch1 on
    wr(1, 1, 3, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      r    = int'($urandom_range(0, 999));
      rst  = (r < 4);
      sync = ($urandom_range(0, 39) == 0);
      we   = ($urandom_range(0, 5) == 0);
      ch   = int'($urandom_range(0, 15));
      mode = int'($urandom_range(0, 3));
      div  = ($urandom_range(0, 19) == 0) ? longint'($urandom_range(0, (1 << 26) - 1))
                                          : longint'($urandom_range(0, 6));
      pick = int'($urandom_range(0, 3));
      duty = (pick == 0) ? 0 : (pick == 1) ? 255 : int'($urandom_range(0, 255));
      step(rst, we, ch, mode, div, duty, sync);
    end

    @(posedge clock);
    #2;
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
